seq_adder: RTL and testbench

//   Parametrised multi-cycle adder/subtractor: adds two WIDTH-bit operands

---
 rtl/seq_adder.sv | 210 +++++++++++++++++++++
 tb/tb_seq_adder.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_adder.sv
`default_nettype none
// ============================================================================
//  Module      : seq_adder
//  Description : Multi-cycle adder/subtractor. Adds two WIDTH-bit operands
//                CHUNK bits per clock, carrying between chunks through a
//                registered carry bit. Valid/ready handshake on both sides,
//                with carry-out, signed-overflow and zero flags on the result.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH      operand/result width in bits
//    CHUNK      bits added per cycle (WIDTH % CHUNK == 0, 1 <= CHUNK <= WIDTH)
//  Ports
//    clk        in   1      clock, rising edge
//    rst_n      in   1      asynchronous active-low reset
//    in_valid   in   1      operands presented
//    in_ready   out  1      block can accept operands (IDLE)
//    a, b       in   WIDTH  operands
//    cin        in   1      carry-in (add) / borrow-in (sub)
//    sub        in   1      0: a+b+cin   1: a-b-cin
//    out_valid  out  1      result available (DONE)
//    out_ready  in   1      consumer accepts result
//    sum        out  WIDTH  result, modulo 2^WIDTH
//    cout       out  1      carry-out; in subtract mode 1 means no borrow
//    ovf        out  1      two's-complement signed overflow
//    zero       out  1      sum == 0
// ============================================================================
module seq_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    // Number of RUN cycles and the chunk-counter width (at least one bit).
    localparam int             N      = WIDTH / CHUNK;
    localparam int             CW     = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0]  LAST_K = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    state_t           r_state;
    state_t           w_state_next;
    logic [CW-1:0]    r_k;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;

    // ------------------------------------------------------------------------
    // Chunk datapath
    // ------------------------------------------------------------------------
    logic [CHUNK-1:0] w_a_chunk;
    logic [CHUNK-1:0] w_b_chunk;
    logic [CHUNK-1:0] w_s;
    logic             w_c;
    logic             w_c_into_msb;
    logic [WIDTH-1:0] w_sum_next;
    logic             w_last;

    assign w_last = (r_k == LAST_K);

    always_comb begin
        w_a_chunk  = '0;
        w_b_chunk  = '0;
        w_sum_next = r_sum;
        w_s        = '0;
        w_c        = 1'b0;

        // Chunk selection is an unrolled mux over constant slices so every
        // part-select stays in range regardless of the counter width.
        for (int i = 0; i < N; i++) begin
            if (r_k == CW'(i)) begin
                w_a_chunk = r_a[i*CHUNK +: CHUNK];
                w_b_chunk = r_b[i*CHUNK +: CHUNK];
            end
        end

        {w_c, w_s} = {1'b0, w_a_chunk} + {1'b0, w_b_chunk}
                   + {{CHUNK{1'b0}}, r_carry};

        for (int i = 0; i < N; i++) begin
            if (r_k == CW'(i)) begin
                w_sum_next[i*CHUNK +: CHUNK] = w_s;
            end
        end
    end

    // Carry into the top bit of the chunk, recovered from the sum bit:
    // s = a ^ b ^ c_in  =>  c_in = s ^ a ^ b. On the last chunk this is the
    // carry into the result MSB, and ovf = c_in(MSB) ^ c_out(MSB).
    assign w_c_into_msb = w_s[CHUNK-1] ^ w_a_chunk[CHUNK-1] ^ w_b_chunk[CHUNK-1];

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state and handshake outputs. Handshake outputs decode only
    // the state register, so there is no combinational path from in_* to out_*.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_k     <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        // Subtraction as a + ~b + ~cin: a - b - cin in two's
                        // complement, with carry-out meaning "no borrow".
                        r_a     <= a;
                        r_b     <= sub ? ~b : b;
                        r_carry <= sub ? ~cin : cin;
                        r_k     <= '0;
                    end
                end
                S_RUN: begin
                    r_sum   <= w_sum_next;
                    r_carry <= w_c;
                    r_k     <= r_k + CW'(1);
                    // Flags are only updated when the final chunk lands, so
                    // the previous result's flags stay visible until then.
                    if (w_last) begin
                        r_cout <= w_c;
                        r_ovf  <= w_c_into_msb ^ w_c;
                        r_zero <= (w_sum_next == '0);
                    end
                end
                default: begin
                    // DONE: hold everything stable for the consumer.
                end
            endcase
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;
    assign zero = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_seq_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_adder
//  Description : Self-checking bench for seq_adder. Three instances (CHUNK =
//                8, 1, 32 at WIDTH = 32) share operand inputs and run each
//                operation in lockstep; results are compared against an
//                arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_adder;

    localparam int NDUT = 3;
    localparam int CHK [NDUT] = '{8, 1, 32};
    localparam longint SMAX = 64'sh7FFF_FFFF;
    localparam longint SMIN = -SMAX - 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;

    logic        in_ready_v  [NDUT];
    logic        out_valid_v [NDUT];
    logic [31:0] sum_v       [NDUT];
    logic        cout_v      [NDUT];
    logic        ovf_v       [NDUT];
    logic        zero_v      [NDUT];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    seq_adder #(.WIDTH(32), .CHUNK(8)) u_dut_c8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_v[0]),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid_v[0]), .out_ready(out_ready),
        .sum(sum_v[0]), .cout(cout_v[0]), .ovf(ovf_v[0]), .zero(zero_v[0])
    );

    seq_adder #(.WIDTH(32), .CHUNK(1)) u_dut_c1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_v[1]),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid_v[1]), .out_ready(out_ready),
        .sum(sum_v[1]), .cout(cout_v[1]), .ovf(ovf_v[1]), .zero(zero_v[1])
    );

    seq_adder #(.WIDTH(32), .CHUNK(32)) u_dut_c32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_v[2]),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid_v[2]), .out_ready(out_ready),
        .sum(sum_v[2]), .cout(cout_v[2]), .ovf(ovf_v[2]), .zero(zero_v[2])
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: plain signed/unsigned 64-bit arithmetic.
    // Returns {cout, ovf, zero, sum}.
    function automatic logic [34:0] model(input logic [31:0] x, input logic [31:0] y,
                                          input logic ci, input logic su);
        longint ux, uy, sx, sy, lc, full, sres;
        logic   co, ov;
        ux = {32'd0, x};
        uy = {32'd0, y};
        sx = $signed(x);
        sy = $signed(y);
        lc = ci ? 64'sd1 : 64'sd0;
        if (!su) begin
            full = ux + uy + lc;
            sres = sx + sy + lc;
            co   = full[32];
        end else begin
            full = ux - uy - lc;
            sres = sx - sy - lc;
            co   = (full >= 0);
        end
        ov = (sres > SMAX) || (sres < SMIN);
        return {co, ov, (full[31:0] == 32'd0), full[31:0]};
    endfunction

    function automatic logic [63:0] outs(input int d);
        return {27'd0, in_ready_v[d], out_valid_v[d], cout_v[d], ovf_v[d], zero_v[d], sum_v[d]};
    endfunction

    task automatic check_reset_state(input string tag);
        for (int d = 0; d < NDUT; d++) begin
            chk($sformatf("%s_dut%0d", tag, d), outs(d), {27'd0, 1'b1, 4'b0000, 32'd0});
        end
    endtask

    // Present operands for one cycle; return just after the accept edge with
    // the operand inputs scrambled so late sampling would be visible.
    task automatic start_op(input logic [31:0] x, input logic [31:0] y,
                            input logic ci, input logic su);
        @(negedge clk);
        a = x; b = y; cin = ci; sub = su; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a   = $urandom;
        b   = $urandom;
        cin = 1'($urandom);
        sub = 1'($urandom);
    endtask

    task automatic wait_check(input string tag, input logic [31:0] x, input logic [31:0] y,
                              input logic ci, input logic su);
        int          lat  [NDUT];
        logic        seen [NDUT];
        logic [34:0] exp;
        int          cyc;
        logic        all_seen;
        exp = model(x, y, ci, su);
        for (int d = 0; d < NDUT; d++) begin
            seen[d] = 1'b0;
            lat[d]  = 0;
        end
        cyc      = 0;
        all_seen = 1'b0;
        while (!all_seen && cyc <= 40) begin
            @(negedge clk);
            all_seen = 1'b1;
            for (int d = 0; d < NDUT; d++) begin
                if (!seen[d] && out_valid_v[d]) begin
                    seen[d] = 1'b1;
                    lat[d]  = cyc;
                end
                if (!seen[d]) all_seen = 1'b0;
            end
            cyc++;
        end
        for (int d = 0; d < NDUT; d++) begin
            if (!seen[d]) begin
                chk($sformatf("%s_timeout_dut%0d", tag, d), 64'd0, 64'd1);
            end else begin
                chk($sformatf("%s_lat_dut%0d", tag, d), 64'(lat[d]), 64'(32 / CHK[d]));
                chk($sformatf("%s_res_dut%0d", tag, d),
                    {29'd0, cout_v[d], ovf_v[d], zero_v[d], sum_v[d]}, {29'd0, exp});
            end
        end
    endtask

    task automatic handshake(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            chk($sformatf("%s_idle_dut%0d", tag, d), {62'd0, in_ready_v[d], out_valid_v[d]}, 64'd2);
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                          input logic ci, input logic su);
        start_op(x, y, ci, su);
        wait_check(tag, x, y, ci, su);
        handshake(tag);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [34:0] exp;
        logic [31:0] rx, ry;
        logic        rc, rs;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state("reset");
        rst_n = 1'b1;

        // Directed arithmetic cases
        run_op("t1",  32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
        run_op("t2a", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        run_op("t2b", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        run_op("t3a", 32'd5, 32'd7, 1'b0, 1'b1);
        run_op("t3b", 32'd7, 32'd5, 1'b1, 1'b1);
        run_op("t3c", 32'h8000_0000, 32'd1, 1'b0, 1'b1);

        // Backpressure: result held, in_valid ignored while DONE
        start_op(32'h1234_5678, 32'h8765_4321, 1'b1, 1'b0);
        wait_check("t4", 32'h1234_5678, 32'h8765_4321, 1'b1, 1'b0);
        exp = model(32'h1234_5678, 32'h8765_4321, 1'b1, 1'b0);
        @(negedge clk);
        in_valid = 1'b1;
        a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D; cin = 1'b1; sub = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            for (int d = 0; d < NDUT; d++) begin
                chk($sformatf("t4_hold%0d_dut%0d", c, d),
                    {27'd0, in_ready_v[d], out_valid_v[d], cout_v[d], ovf_v[d], zero_v[d], sum_v[d]},
                    {27'd0, 1'b0, 1'b1, exp});
            end
        end
        in_valid = 1'b0;
        handshake("t4");
        run_op("t4n", 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, 1'b1);

        // Reset in RUN cycle 2 after a result with nonzero flags
        run_op("t5p", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        start_op(32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("t5_rst");
        @(negedge clk);
        rst_n = 1'b1;
        run_op("t5n", 32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0);

        // Randomized operations
        for (int i = 0; i < 1000; i++) begin
            rx = $urandom;
            ry = $urandom;
            rc = 1'($urandom);
            rs = 1'($urandom);
            if (i % 16 == 0) ry = rx;
            if (i % 16 == 1) ry = ~rx;
            run_op($sformatf("rnd%0d", i), rx, ry, rc, rs);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
